// File: rtl/mod_addsub_ctrl_pkg.sv
// Purpose: shared widths, FSM state encoding and opcode constants for mod_addsub_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mod_addsub_ctrl_pkg;

  localparam int N_DEF  = 512;  // operand/modulus width
  localparam int AW_DEF = 514;  // adder operand width, must be >= N+2

  // 3-bit state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE1 = 3'd1;
  localparam logic [2:0] ST_WAIT1  = 3'd2;
  localparam logic [2:0] ST_ISSUE2 = 3'd3;
  localparam logic [2:0] ST_WAIT2  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ISSUE1 = ST_ISSUE1,
    WAIT1  = ST_WAIT1,
    ISSUE2 = ST_ISSUE2,
    WAIT2  = ST_WAIT2,
    DONE   = ST_DONE
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Purpose: modular add/sub initiator driving one shared multi-precision adder (R = A +/- B mod M).
// Latency: with a 1-cycle adder, done 5 cycles after start (3 for subtract with A >= B).
// Backpressure: start ignored while busy; waits indefinitely on add_done, no timeout.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, subtract          request (accepted when busy==0) and op select, sampled together
//   in_a, in_b, in_m         operands (A, B < M) and modulus, latched on acceptance
//   busy, done, result       in-flight flag, one-cycle completion pulse, held modular result
//   add_start, add_subtract  adder request pulse and subtract select
//   add_a, add_b             zero-extended adder operands
//   add_result, add_done     adder sum (MSB = carry/borrow) and result-valid strobe
module mod_addsub_ctrl
  import mod_addsub_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          subtract,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          add_start,
  output logic          add_subtract,
  output logic [AW-1:0] add_a,
  output logic [AW-1:0] add_b,
  input  logic [AW:0]   add_result,
  input  logic          add_done
);

  state_e         state_q, state_d;
  logic           op_q, op_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   m_q, m_d;
  logic [AW:0]    r1_q, r1_d;
  logic [N-1:0]   result_q, result_d;
  logic           second_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r1_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      r1_q     <= r1_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    r1_d     = r1_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d    = subtract;
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          state_d = ISSUE1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE1: state_d = WAIT1;
      WAIT1: begin
        if (add_done) begin
          r1_d = add_result;
          // Add always needs the trial subtraction of M; sub only needs
          // the +M correction when the first difference went negative.
          if (op_q == OP_ADD || add_result[AW]) begin
            state_d = ISSUE2;
          end else begin
            result_d = add_result[N-1:0];
            state_d  = DONE;
          end
        end
      end
      ISSUE2: state_d = WAIT2;
      WAIT2: begin
        if (add_done) begin
          // For add, a borrow out of r1 - M means r1 was already reduced.
          if (op_q == OP_ADD && add_result[AW]) begin
            result_d = r1_q[N-1:0];
          end else begin
            result_d = add_result[N-1:0];
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand mux: ISSUE2/WAIT2 present the correction step, everything else
  // presents the first operation (all-zero after reset since regs are cleared).
  assign second_op    = (state_q == ISSUE2) || (state_q == WAIT2);
  assign add_a        = second_op ? r1_q[AW-1:0] : {{(AW-N){1'b0}}, a_q};
  assign add_b        = second_op ? {{(AW-N){1'b0}}, m_q} : {{(AW-N){1'b0}}, b_q};
  assign add_subtract = second_op ? ~op_q : op_q;
  assign add_start    = (state_q == ISSUE1) || (state_q == ISSUE2);
  assign busy         = (state_q == ISSUE1) || (state_q == WAIT1) ||
                        (state_q == ISSUE2) || (state_q == WAIT2);
  assign done         = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl: 1-cycle registered adder model, scoreboard of
// expected results computed with plain modular arithmetic, separate monitor.
module tb_mod_addsub_ctrl;

  localparam int N  = 512;
  localparam int AW = 514;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          subtract = 1'b0;
  logic [N-1:0]  in_a = '0, in_b = '0, in_m = '0;
  logic          busy, done;
  logic [N-1:0]  result;
  logic          add_start, add_subtract;
  logic [AW-1:0] add_a, add_b;
  logic [AW:0]   add_res_q = '0;
  logic          add_done;
  logic          hold_done = 1'b0;

  mod_addsub_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy), .done(done), .result(result),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_a(add_a), .add_b(add_b),
    .add_result(add_res_q), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // Adder model: operands registered on the add_start edge, result valid from the next cycle.
  always @(posedge clk) begin
    if (add_start)
      add_res_q <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b})
                                : ({1'b0, add_a} + {1'b0, add_b});
  end
  assign add_done = ~hold_done;

  typedef struct {
    logic [N-1:0] res;
    int           lat;     // 0 = latency not checked
    int           pulses;
    int           c0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a, b, m, input logic sub);
    logic [N+1:0] t;
    if (!sub) begin
      t = {2'b0, a} + {2'b0, b};
      if (t >= {2'b0, m}) t = t - {2'b0, m};
    end else if (a >= b) begin
      t = {2'b0, a} - {2'b0, b};
    end else begin
      t = {2'b0, a} + {2'b0, m} - {2'b0, b};
    end
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: counts adder requests and pops the scoreboard on every done pulse.
  initial begin
    int   pulses = 0;
    logic prev_start = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0;
        prev_start = 1'b0;
      end else begin
        if (add_start) begin
          pulses++;
          chk("add_start_gap", {{N{1'b0}}, prev_start}, '0);
        end
        prev_start = add_start;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", {{N{1'b0}}, done}, '0);
          end else begin
            e = sb.pop_front();
            chk("result", {1'b0, result}, {1'b0, e.res});
            if (e.lat > 0) chk("latency", (N+1)'(cyc - e.c0), (N+1)'(e.lat));
            chk("add_start_pulses", (N+1)'(pulses), (N+1)'(e.pulses));
            chk("busy_in_done", {{N{1'b0}}, busy}, '0);
          end
          pulses = 0;
        end
      end
    end
  end

  // Presents one request; align=0 issues in the current (already negedge-aligned) cycle.
  task automatic issue(input logic [N-1:0] a, b, m, input logic sub, input bit chk_lat,
                       input bit align, output int c0);
    exp_t e;
    int   w;
    if (align) @(negedge clk);
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("issue_wait_busy", {{N{1'b0}}, busy}, '0);
    in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
    e.res    = ref_mod(a, b, m, sub);
    e.pulses = (sub && a >= b) ? 1 : 2;
    e.lat    = chk_lat ? ((sub && a >= b) ? 3 : 5) : 0;
    e.c0     = cyc;
    c0       = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Inputs change after acceptance; the DUT must ignore them.
    in_a = rand_wide(); in_b = rand_wide(); in_m = rand_wide(); subtract = $urandom_range(0, 1);
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("wait_done_timeout", {{N{1'b0}}, done}, {{N{1'b0}}, 1'b1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int           c0;
    logic [N-1:0] a, b, m;

    #3;
    chk("rst_busy",  {{N{1'b0}}, busy}, '0);
    chk("rst_done",  {{N{1'b0}}, done}, '0);
    chk("rst_start", {{N{1'b0}}, add_start}, '0);
    chk("rst_sub",   {{N{1'b0}}, add_subtract}, '0);
    chk("rst_result", {1'b0, result}, '0);
    chk("rst_add_a", (N+1)'(add_a), '0);
    chk("rst_add_b", (N+1)'(add_b), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    issue(7, 9, 13, 1'b0, 1, 1, c0);   // 3, two-op path
    issue(5, 8, 13, 1'b0, 1, 1, c0);   // sum equals M -> 0
    issue(3, 9, 13, 1'b1, 1, 1, c0);   // negative difference -> 7
    issue(9, 3, 13, 1'b1, 1, 1, c0);   // 6, single-op path
    issue(4, 4, 13, 1'b1, 1, 1, c0);   // A == B -> 0
    issue(12, 12, 13, 1'b0, 1, 1, c0); // 11

    // start while busy (WAIT1) with different operands must be ignored
    issue(10, 11, 13, 1'b0, 1, 1, c0);
    @(negedge clk);
    in_a = 1; in_b = 2; in_m = 7; subtract = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // back-to-back: start presented in the DONE cycle
    wait_done();
    issue(2, 6, 13, 1'b1, 1, 0, c0);   // 9
    wait_done();
    issue(8, 1, 13, 1'b1, 1, 0, c0);   // 7

    // add_done held low for a while during WAIT1
    wait_done();
    @(negedge clk);
    hold_done = 1'b1;
    issue(11, 6, 13, 1'b0, 0, 0, c0);  // 4
    repeat (10) @(negedge clk);
    hold_done = 1'b0;

    // reset during WAIT2: no done, everything cleared
    issue(7, 9, 13, 1'b0, 1, 1, c0);
    while (cyc < c0 + 4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {{N{1'b0}}, busy}, '0);
    chk("midrst_done", {{N{1'b0}}, done}, '0);
    chk("midrst_result", {1'b0, result}, '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(6, 9, 13, 1'b1, 1, 1, c0);   // 10

    // Randomized: mix of small and full-width moduli
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1)) m = (N)'($urandom_range(2, 1000));
      else begin
        m = rand_wide();
        if (m < 2) m = 2;
      end
      a = rand_wide() % m;
      b = ($urandom_range(0, 7) == 0) ? a : rand_wide() % m;
      issue(a, b, m, 1'(($urandom_range(0, 1))), 1, ($urandom_range(0, 2) != 0), c0);
    end

    begin
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    chk("scoreboard_drained", (N+1)'(sb.size()), '0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
